seq_mult16: RTL and testbench

Unsigned 16x16 shift-and-add sequential multiplier producing a 32-bit product. It sits directly upstream of the 32-bit data register: `product` drives the register's 32-bit data input, and `done` marks the cycle in which a fresh result is presented. It uses one adder and one iteration per clock, trading latency for area.

---
 rtl/seq_mult16.sv | 102 ++++++++++
 tb/tb_seq_mult16.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult16.sv
// seq_mult16: unsigned WIDTH x WIDTH shift-and-add multiplier, one partial product per clock.
// Latency: 16 clocks from the accepted start edge to done; next start accepted 18 clocks after the previous one.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
module seq_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 res_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    // Held low on the first edge after reset release so a start coincident
    // with the release edge can never launch an operation.
    logic                 armed_q;
    logic [2*WIDTH-1:0]   sum;

    // State register and datapath registers; reset clears everything at once.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            armed_q   <= 1'b1;
        end
    end

    // Next-state and datapath: load operands on accept, one add/shift per RUN cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        sum       = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            S_IDLE: begin
                if (start_i && armed_q) begin
                    state_d  = S_RUN;
                    mcand_d  = {{WIDTH{1'b0}}, a_i};
                    mplier_d = b_i;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            S_RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                // Final iteration publishes the result; product is otherwise held.
                if (count_q == LAST_ITER) begin
                    product_d = sum;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_mult16.sv
// tb_seq_mult16: random and directed stimulus against a cycle-level behavioural model of seq_mult16.
// The model tracks time since accept and the arithmetic product a*b; compared on every falling edge.
// Includes a downstream 32-bit register that captures product on each done cycle.
module tb_seq_mult16;

    logic        clk_i = 1'b0;
    logic        res_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] a_i = 16'h0;
    logic [15:0] b_i = 16'h0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] product_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    seq_mult16 #(.WIDTH(16)) dut (
        .clk_i     (clk_i),
        .res_i     (res_i),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .product_o (product_o)
    );

    // Downstream data register fed by the multiplier.
    logic [31:0] ds_q = 32'h0;
    always @(posedge clk_i or posedge res_i) begin
        if (res_i)       ds_q <= 32'h0;
        else if (done_o) ds_q <= product_o;
    end

    // Behavioural model: m_cnt is the number of edges since accept (0 = idle),
    // busy while non-zero, done at 17, result published on the 16th iteration.
    int          m_cnt   = 0;
    logic        m_armed = 1'b0;
    logic [31:0] m_exp   = 32'h0;
    logic [31:0] m_prod  = 32'h0;
    logic [31:0] m_ds    = 32'h0;

    always @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            m_cnt   <= 0;
            m_armed <= 1'b0;
            m_exp   <= 32'h0;
            m_prod  <= 32'h0;
            m_ds    <= 32'h0;
        end else begin
            m_armed <= 1'b1;
            if (m_cnt == 0) begin
                if (m_armed && start_i) begin
                    m_cnt <= 1;
                    m_exp <= {16'h0, a_i} * {16'h0, b_i};
                end
            end else if (m_cnt == 17) begin
                m_cnt <= 0;
                m_ds  <= m_prod;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 16) m_prod <= m_exp;
            end
        end
    end

    int cyc       = 0;
    int done_cnt  = 0;
    int last_done = -1;
    bit track     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: wait for the falling edge and compare every output against the model.
    task automatic tick();
        @(negedge clk_i);
        cyc++;
        chk("busy", 32'(busy_o), 32'(m_cnt != 0));
        chk("done", 32'(done_o), 32'(m_cnt == 17));
        chk("product", product_o, m_prod);
        chk("downstream", ds_q, m_ds);
        if (done_o) begin
            done_cnt++;
            if (track && last_done >= 0) chk("done_spacing", 32'(cyc - last_done), 32'd18);
            last_done = cyc;
        end
    endtask

    task automatic run_mult(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] lit, input int inject_at,
                            input bit do_hold, input logic [31:0] hold_val);
        int g;
        int busy_n;
        int d0;
        bit seen;
        g = 0;
        while ((busy_o || m_cnt != 0) && g < 40) begin
            tick();
            g++;
        end
        if (g >= 40) chk({name, "_idle_wait"}, 32'(busy_o), 32'd0);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        d0      = done_cnt;
        busy_n  = 0;
        seen    = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (busy_o) busy_n++;
            if (done_o && !seen) begin
                seen = 1'b1;
                chk({name, "_latency"}, 32'(c - 1), 32'd16);
                chk({name, "_product"}, product_o, lit);
            end
            if (do_hold && c == 8) chk({name, "_hold"}, product_o, hold_val);
            start_i = (c == inject_at);
            if (c == inject_at) begin
                a_i = 16'd2;
                b_i = 16'd2;
            end else begin
                a_i = 16'($urandom);
                b_i = 16'($urandom);
            end
        end
        start_i = 1'b0;
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'd17);
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int d0;
        int g;
        logic [15:0] ra;
        logic [15:0] rb;

        // Reset values, with start held high across the release edge.
        #1 res_i = 1'b1;
        #1;
        chk("reset_product", product_o, 32'h0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        tick();
        tick();
        start_i = 1'b1;
        a_i = 16'd9;
        b_i = 16'd9;
        tick();
        #4 res_i = 1'b0;
        tick();
        chk("no_accept_on_release", 32'(busy_o), 32'd0);
        start_i = 1'b0;
        tick();

        run_mult("basic", 16'd3, 16'd5, 32'h0000_000F, 0, 1'b0, 32'h0);
        run_mult("max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 1'b0, 32'h0);
        run_mult("msb", 16'h8000, 16'h0002, 32'h0001_0000, 0, 1'b0, 32'h0);
        run_mult("zero", 16'h0000, 16'h1234, 32'h0000_0000, 0, 1'b1, 32'h0001_0000);
        run_mult("busy_start", 16'd7, 16'd9, 32'd63, 5, 1'b0, 32'h0);
        d0 = done_cnt;
        repeat (20) tick();
        chk("busy_start_no_second_done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset in the middle of a run.
        start_i = 1'b1;
        a_i = 16'd100;
        b_i = 16'd200;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start_i = 1'b0;
            a_i = 16'($urandom);
            b_i = 16'($urandom);
        end
        #2 res_i = 1'b1;
        #1;
        chk("midrst_product", product_o, 32'h0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        tick();
        tick();
        #4 res_i = 1'b0;
        d0 = done_cnt;
        repeat (40) tick();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_mult("midrst_rerun", 16'd100, 16'd200, 32'h0000_4E20, 0, 1'b0, 32'h0);

        // A few random single operations with the product computed here.
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_mult("random", ra, rb, {16'h0, ra} * {16'h0, rb}, 0, 1'b0, 32'h0);
        end

        // Back-to-back streaming: start held high so every first IDLE edge accepts.
        track     = 1'b1;
        last_done = -1;
        d0        = done_cnt;
        g         = 0;
        start_i   = 1'b1;
        while ((done_cnt - d0) < 20 && g < 500) begin
            tick();
            a_i = 16'($urandom);
            b_i = 16'($urandom);
            g++;
        end
        chk("stream_results", 32'(done_cnt - d0), 32'd20);
        start_i = 1'b0;
        track   = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
